// File: rtl/keypad_entry.sv
// Keypad numeric entry: BCD digit buffer with backspace/clear, sequential BCD-to-binary
// conversion on confirm, and a valid/ready result port. Define KEYPAD_ENTRY_AUTOCONFIRM_EN to auto-confirm a full buffer.
module keypad_entry #(
  parameter int DIGITS = 4,
  parameter int VAL_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           key_edge,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   digits,
  output logic [3:0]            count,
  output logic                  busy,
  output logic                  out_valid,
  output logic [VAL_W-1:0]      out_value,
  output logic                  err
);

  localparam int         DW      = 4 * DIGITS;
  localparam logic [3:0] CNT_MAX = 4'(DIGITS);
  localparam logic [2:0] IDX_TOP = 3'(DIGITS - 1);

  typedef enum logic [1:0] {ENTRY, CONVERT, HOLD} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     digits_q, digits_d;
  logic [3:0]        count_q, count_d;
  logic [VAL_W-1:0]  acc_q, acc_d;
  logic [2:0]        idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [VAL_W-1:0]  out_value_q, out_value_d;
  logic              err_q, err_d;

  logic [3:0]        key_code;
  logic              multi_key;
  logic              valid_key;
  logic [3:0]        cur_digit;
  logic [VAL_W-1:0]  acc_next;

  // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    key_code = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (key_edge[k]) key_code = 4'(k);
    end
  end

  // Clearing the lowest set bit leaves something only when two or more keys fired together.
  assign multi_key = (key_edge & (key_edge - 16'd1)) != 16'd0;
  assign valid_key = (|key_edge) && !multi_key && (key_code <= 4'd12);

  assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];
  assign acc_next  = (acc_q << 3) + (acc_q << 1) + VAL_W'(cur_digit);

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    count_d     = count_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    err_d       = multi_key;

    case (state_q)
      ENTRY: begin
        if (valid_key) begin
          if (key_code <= 4'd9) begin
            if (count_q == CNT_MAX) begin
              err_d = 1'b1;
            end else begin
              digits_d = (digits_q << 4) | DW'(key_code);
              count_d  = count_q + 4'd1;
`ifdef KEYPAD_ENTRY_AUTOCONFIRM_EN
              if (count_q == CNT_MAX - 4'd1) begin
                acc_d   = '0;
                idx_d   = IDX_TOP;
                state_d = CONVERT;
              end
`endif
            end
          end else if (key_code == 4'd10) begin
            if (count_q == 4'd0) begin
              err_d = 1'b1;
            end else begin
              digits_d = digits_q >> 4;
              count_d  = count_q - 4'd1;
            end
          end else if (key_code == 4'd11) begin
            digits_d = '0;
            count_d  = 4'd0;
          end else begin
            if (count_q == 4'd0) begin
              err_d = 1'b1;
            end else begin
              acc_d   = '0;
              idx_d   = IDX_TOP;
              state_d = CONVERT;
            end
          end
        end
      end

      CONVERT: begin
        err_d = multi_key || valid_key;
        acc_d = acc_next;
        idx_d = idx_q - 3'd1;
        if (idx_q == 3'd0) begin
          out_value_d = acc_next;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        err_d = multi_key || valid_key;
        if (out_ready) begin
          out_valid_d = 1'b0;
          digits_d    = '0;
          count_d     = 4'd0;
          state_d     = ENTRY;
        end
      end

      default: state_d = ENTRY;
    endcase

    busy_d = (state_d != ENTRY);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ENTRY;
      digits_q    <= '0;
      count_q     <= 4'd0;
      acc_q       <= '0;
      idx_q       <= 3'd0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      err_q       <= err_d;
    end
  end

  assign digits    = digits_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign err       = err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: expected results queued at confirm, popped by a monitor
// when out_valid rises; err pulses counted independently and reconciled at the end.
module tb_keypad_entry;

  localparam int DIGITS = 4;
  localparam int VAL_W  = 14;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [15:0]          key_edge;
  logic                 out_ready;
  logic [4*DIGITS-1:0]  digits;
  logic [3:0]           count;
  logic                 busy;
  logic                 out_valid;
  logic [VAL_W-1:0]     out_value;
  logic                 err;

  keypad_entry #(.DIGITS(DIGITS), .VAL_W(VAL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_edge  (key_edge),
    .out_ready (out_ready),
    .digits    (digits),
    .count     (count),
    .busy      (busy),
    .out_valid (out_valid),
    .out_value (out_value),
    .err       (err)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] K0 = 16'h0001, K1 = 16'h0002, K2 = 16'h0004, K3 = 16'h0008;
  localparam logic [15:0] K4 = 16'h0010, K5 = 16'h0020, K7 = 16'h0080, K8 = 16'h0100;
  localparam logic [15:0] K9 = 16'h0200, KBS = 16'h0400, KCLR = 16'h0800, KOK = 16'h1000;
  localparam logic [15:0] K13 = 16'h2000;

  int total = 0;
  int bad   = 0;
  int exp_err  = 0;
  int err_seen = 0;
  logic [VAL_W-1:0] exp_q[$];
  logic             valid_prev = 1'b0;
  logic [VAL_W-1:0] held_value = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [15:0] k);
    key_edge = k;
    @(posedge clk); #1;
    key_edge = 16'h0000;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called right after the edge that starts conversion; checks exact latency.
  task automatic wait_result(input int exp_val);
    exp_q.push_back(VAL_W'(exp_val));
    check("busy_convert", 32'(busy), 32'd1);
    repeat (DIGITS - 1) begin
      @(posedge clk); #1;
      check("valid_early", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    check("valid_on_time", 32'(out_valid), 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_valid", 32'(out_valid), 32'd0);
    check("hs_count", 32'(count), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);
    check("hs_digits", 32'(digits), 32'h0);
  endtask

  // Monitor: pop on each new result presentation, and check the held value stays put.
  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_seen++;
      if (out_valid && !valid_prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result: got %0d expected none", out_value);
        end else begin
          logic [VAL_W-1:0] e;
          e = exp_q.pop_front();
          if (out_value !== e) begin
            bad++;
            $display("FAIL result_value: got %0d expected %0d", out_value, e);
          end
        end
        held_value = out_value;
      end else if (out_valid && valid_prev && out_value !== held_value) begin
        total++;
        bad++;
        $display("FAIL hold_stable: got %0d expected %0d", out_value, held_value);
      end
    end
    valid_prev = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; key_edge = 16'h0000; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_value", 32'(out_value), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Basic entry; out_ready high while out_valid low must have no effect.
    out_ready = 1'b1;
    press(K1); press(K2); press(K3);
    out_ready = 1'b0;
    check("entry_digits", 32'(digits), 32'h0123);
    check("entry_count", 32'(count), 32'd3);
    check("entry_err", 32'(err), 32'd0);

    // Backspace then digit, confirm, long hold, handshake.
    press(KBS);
    check("bs_digits", 32'(digits), 32'h0012);
    check("bs_count", 32'(count), 32'd2);
    press(K4);
    check("d4_digits", 32'(digits), 32'h0124);
    press(KOK);
    check("conf_digits", 32'(digits), 32'h0124);
    wait_result(124);
    idle(10);
    check("hold_value", 32'(out_value), 32'd124);
    check("hold_valid", 32'(out_valid), 32'd1);
    handshake();

    // Key in the cycle right after the handshake is accepted; clear on data.
    press(K5);
    check("post_hs_digits", 32'(digits), 32'h0005);
    check("post_hs_count", 32'(count), 32'd1);
    press(KCLR);
    check("clr_digits", 32'(digits), 32'h0);
    check("clr_count", 32'(count), 32'd0);
    check("clr_err", 32'(err), 32'd0);

    // Rejections on empty buffer and multi-key.
    press(KOK); exp_err++;
    check("empty_ok_err", 32'(err), 32'd1);
    check("empty_ok_busy", 32'(busy), 32'd0);
    idle(1);
    check("err_one_cycle", 32'(err), 32'd0);
    press(KBS); exp_err++;
    check("empty_bs_err", 32'(err), 32'd1);
    idle(1);
    press(K7);
    press(16'h0006); exp_err++;
    check("multi_err", 32'(err), 32'd1);
    check("multi_digits", 32'(digits), 32'h0007);
    check("multi_count", 32'(count), 32'd1);
    idle(1);
    press(K13);
    check("ign_err", 32'(err), 32'd0);
    check("ign_digits", 32'(digits), 32'h0007);
    press(KCLR);

    // Full buffer.
    press(K9); press(K9); press(K9);
`ifdef KEYPAD_ENTRY_AUTOCONFIRM_EN
    press(K9);
    check("full_digits", 32'(digits), 32'h9999);
    wait_result(9999);
`else
    press(K9);
    check("full_busy", 32'(busy), 32'd0);
    press(K5); exp_err++;
    check("full_err", 32'(err), 32'd1);
    check("full_digits", 32'(digits), 32'h9999);
    check("full_count", 32'(count), 32'd4);
    idle(1);
    press(KOK);
    wait_result(9999);
`endif
    handshake();

    // Key during HOLD is rejected and the result is untouched.
    press(K2); press(K5); press(KOK);
    wait_result(25);
    press(K7); exp_err++;
    check("hold_key_err", 32'(err), 32'd1);
    check("hold_key_value", 32'(out_value), 32'd25);
    check("hold_key_digits", 32'(digits), 32'h0025);
    idle(1);
    handshake();

    // Reset mid-conversion aborts with no output.
    press(K8); press(KOK);
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_digits", 32'(digits), 32'h0);
    check("abort_count", 32'(count), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_value", 32'(out_value), 32'd0);
    idle(DIGITS + 3);
    check("abort_no_valid", 32'(out_valid), 32'd0);

    check("err_pulses", 32'(err_seen), 32'(exp_err));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
